// File: rtl/num_pkg.sv
// Shared types and fixed-point helpers for the num_* sequential arithmetic blocks.
package num_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MUL1, MUL2, ADD, FIN} horner_state_e;

  // Widest product any num_* block may hand to the rescale helper.
  localparam int PROD_MAX_W = 128;

  typedef logic signed [PROD_MAX_W-1:0] wide_t;

  // Drop the fractional bits of a full-width fixed-point product (floor, no rounding).
  // Callers keep the low WIDTH bits of the result, which gives mod-2^WIDTH wrap.
  function automatic wide_t fx_rescale(input wide_t p, input int frac);
    return p >>> frac;
  endfunction

endpackage

// File: rtl/num_smul_pipe.sv
// Two-stage signed multiplier: operand registers followed by a full-width product register.
module num_smul_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] prod
);

  logic signed [WIDTH-1:0]   a_p0;
  logic signed [WIDTH-1:0]   b_p0;
  logic signed [2*WIDTH-1:0] prod_p1;

  // stage p0 captures operands, stage p1 captures their product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0    <= '0;
      b_p0    <= '0;
      prod_p1 <= '0;
    end else if (en) begin
      a_p0    <= a;
      b_p0    <= b;
      prod_p1 <= (2*WIDTH)'(a_p0) * (2*WIDTH)'(b_p0);
    end
  end

  assign prod = prod_p1;

endmodule

// File: rtl/num_shorner.sv
// Horner-rule signed fixed-point polynomial evaluator with go/done handshake,
// sharing one pipelined multiplier across all iterations.
module num_shorner
  import num_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int DEGREE     = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      coef_read_data,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic [WIDTH-1:0]      out,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = ADDR_WIDTH'(DEGREE);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(DEGREE - 1);

  horner_state_e state;
  horner_state_e state_nxt;

  logic signed [WIDTH-1:0]   acc;
  logic signed [WIDTH-1:0]   x_r;
  logic [ADDR_WIDTH-1:0]     idx;
  logic signed [2*WIDTH-1:0] prod;
  wide_t                     prod_wide;
  wide_t                     prod_shift;
  logic signed [WIDTH-1:0]   scaled;
  logic signed [WIDTH-1:0]   acc_add;
  logic                      mul_en;
  logic                      unused_hi;

  assign mul_en = (state == MUL1) || (state == MUL2);

  num_smul_pipe #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (mul_en),
    .a     (acc),
    .b     (x_r),
    .prod  (prod)
  );

  assign prod_wide  = wide_t'(prod);
  assign prod_shift = fx_rescale(prod_wide, FRAC);
  assign scaled     = prod_shift[WIDTH-1:0];
  assign unused_hi  = ^prod_shift[PROD_MAX_W-1:WIDTH];
  assign acc_add    = scaled + $signed(coef_read_data);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    state_nxt = !go ? IDLE : ((DEGREE == 0) ? FIN : MUL1);
      MUL1:    state_nxt = go ? MUL2 : IDLE;
      MUL2:    state_nxt = go ? ADD : IDLE;
      ADD:     state_nxt = !go ? IDLE : ((idx == '0) ? FIN : MUL1);
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An abort (go low mid-run) leaves acc, idx and x_r untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      x_r   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (go) x_r <= $signed(x);
        LOAD: if (go) begin
          acc <= $signed(coef_read_data);
          idx <= FIRST_IDX;
        end
        ADD: if (go) begin
          acc <= acc_add;
          if (idx != '0) idx <= idx - ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign coef_addr = (state == LOAD) ? TOP_ADDR : idx;
  assign out       = acc;
  assign done      = (state == FIN);

endmodule
